// File: rtl/timer_scheduler.sv
// Round-robin front end sharing one Avalon-MM interval timer among N_REQ requesters.
// Each grant programs a one-shot period, waits for the irq, clears status, then pulses done.
module timer_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_period,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic [2:0]          tmr_address,
    output logic                tmr_chipselect,
    output logic                tmr_write_n,
    output logic [15:0]         tmr_writedata,
    input  logic                tmr_irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_PL   = 3'd1;
    localparam logic [2:0] S_WR_PH   = 3'd2;
    localparam logic [2:0] S_WR_CTL  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_WR_STOP = 3'd5;
    localparam logic [2:0] S_WR_STAT = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [31:0]      period_q, period_d;
    logic             cancel_q, cancel_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic             found;
    logic [ID_W-1:0]  pick;
    int               idx;
    logic [31:0]      pick_period;

    // Search starts one past the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    assign pick_period = req_period[32*int'(pick) +: 32];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        period_d = period_q;
        cancel_d = cancel_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d  = S_WR_PL;
                    ptr_d    = pick;
                    grant_d  = pick;
                    cancel_d = 1'b0;
                    period_d = (pick_period == 32'd0) ? 32'd1 : pick_period;
                end
            end
            S_WR_PL:  state_d = S_WR_PH;
            S_WR_PH:  state_d = S_WR_CTL;
            S_WR_CTL: state_d = S_WAIT;
            S_WAIT: begin
                if (tmr_irq) begin
                    state_d = S_WR_STAT;
                end else if (!req[grant_q]) begin
                    state_d  = S_WR_STOP;
                    cancel_d = 1'b1;
                end
            end
            S_WR_STOP: state_d = S_WR_STAT;
            S_WR_STAT: state_d = cancel_q ? S_IDLE : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_d = '0;
        if (state_d == S_DONE) begin
            done_d = N_REQ'(1) << grant_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= ID_W'(N_REQ - 1);
            grant_q  <= '0;
            period_q <= 32'd1;
            cancel_q <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            period_q <= period_d;
            cancel_q <= cancel_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (state_q)
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = period_q[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = period_q[31:16];
            end
            S_WR_CTL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0005;
            end
            S_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
            S_WR_STAT: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;
    assign done     = done_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Randomized transaction bench for timer_scheduler against a transaction-level model
// of round-robin arbitration and the expected Avalon write sequence.
module tb_timer_scheduler;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_period;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   grant_id;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    int n_chk = 0;
    int n_err = 0;
    int last  = 3;

    timer_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_period     (req_period),
        .done           (done),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus bundle {chipselect, write_n, address, writedata}
    task automatic check_wr(input string tag, input logic [2:0] a,
                            input logic [15:0] d);
        check(tag, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {11'd0, 1'b1, 1'b0, a, d});
    endtask

    task automatic check_idle(input string tag);
        check(tag, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (m[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    // mode: 0 irq, 1 cancel in WAIT, 2 cancel+irq same cycle, 3 req dropped at WR_PL
    // Entered and left at a negedge with the DUT idle.
    task automatic txn(input logic [3:0] mask, input int mode, input int wt_in,
                       input bit force_p, input logic [31:0] fp);
        int          g;
        int          wt;
        logic [31:0] p;
        wt  = (mode == 3) ? 0 : wt_in;
        req = mask;
        for (int i = 0; i < 4; i++) req_period[32*i +: 32] = $urandom;
        g = rr_pick(mask, last);
        if (force_p) req_period[32*g +: 32] = fp;
        p = req_period[32*g +: 32];
        if (p == 32'd0) p = 32'd1;
        @(negedge clk);
        check("grant_busy", {31'd0, busy}, 32'd1);
        check("grant_id", {30'd0, grant_id}, g);
        check_wr("wr_pl", 3'd2, p[15:0]);
        for (int i = 0; i < 4; i++) req_period[32*i +: 32] = $urandom;
        if (mode == 3) req[g] = 1'b0;
        @(negedge clk);
        check_wr("wr_ph", 3'd3, p[31:16]);
        tmr_irq = 1'b1;
        @(negedge clk);
        tmr_irq = 1'b0;
        check_wr("wr_ctl", 3'd1, 16'h0005);
        last = g;
        for (int w = 0; w <= wt; w++) begin
            @(negedge clk);
            check_idle("wait_bus");
            check("wait_busy", {31'd0, busy}, 32'd1);
            check("wait_done", {28'd0, done}, 32'd0);
        end
        if (mode == 0) begin
            tmr_irq = 1'b1;
        end else if (mode == 2) begin
            tmr_irq = 1'b1;
            req[g]  = 1'b0;
        end else begin
            req[g] = 1'b0;
        end
        @(negedge clk);
        tmr_irq = 1'b0;
        if (mode == 1 || mode == 3) begin
            check_wr("wr_stop", 3'd1, 16'h0008);
            check("stop_done", {28'd0, done}, 32'd0);
            @(negedge clk);
        end
        check_wr("wr_stat", 3'd0, 16'h0000);
        check("stat_done", {28'd0, done}, 32'd0);
        @(negedge clk);
        if (mode == 0 || mode == 2) begin
            check("done_pulse", {28'd0, done}, 32'd1 << g);
            check_idle("done_bus");
            check("done_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {28'd0, done}, 32'd0);
        check_idle("end_bus");
    endtask

    initial begin
        reset      = 1'b1;
        req        = 4'b0000;
        req_period = '0;
        tmr_irq    = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_gid", {30'd0, grant_id}, 32'd0);
        check_idle("rst_bus");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last  = 3;

        tmr_irq = 1'b1;
        @(negedge clk);
        tmr_irq = 1'b0;
        check("irq_idle_busy", {31'd0, busy}, 32'd0);
        check_idle("irq_idle_bus");

        txn(4'b0001, 0, 2, 1'b1, 32'h0001_0003);
        txn(4'b1011, 0, 1, 1'b0, 32'd0);
        txn(4'b1011, 0, 0, 1'b0, 32'd0);
        txn(4'b1011, 0, 3, 1'b0, 32'd0);
        txn(4'b1011, 0, 1, 1'b0, 32'd0);
        txn(4'b0100, 0, 1, 1'b1, 32'd0);
        txn(4'b0010, 1, 2, 1'b0, 32'd0);
        txn(4'b1000, 2, 1, 1'b0, 32'd0);
        txn(4'b0001, 3, 0, 1'b0, 32'd0);

        req = 4'b0100;
        req_period[95:64] = 32'd0;
        @(negedge clk);
        check_wr("rst_pl", 3'd2, 16'h0001);
        @(negedge clk);
        check_wr("rst_ph", 3'd3, 16'h0000);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_gid", {30'd0, grant_id}, 32'd0);
        check("mid_rst_done", {28'd0, done}, 32'd0);
        check_idle("mid_rst_bus");
        @(negedge clk);
        reset = 1'b0;
        last  = 3;
        txn(4'b0110, 0, 1, 1'b0, 32'd0);

        for (int t = 0; t < 24; t++) begin
            txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
